// File: rtl/clos_port_rx.sv
// Clocked receiving end of one Clos output virtual circuit: synchronises 1-of-4 + eof
// wires, decodes 4-phase tokens, acknowledges them and buffers words behind valid/ready.
module clos_port_rx #(
  parameter int DW    = 8,
  parameter int SCN   = DW / 2,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SCN-1:0]             d0,
  input  logic [SCN-1:0]             d1,
  input  logic [SCN-1:0]             d2,
  input  logic [SCN-1:0]             d3,
  input  logic                       d4,
  output logic                       a,
  output logic                       a4,
  output logic [DW-1:0]              out_data,
  output logic                       out_eof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err,
  output logic [1:0]                 state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = 4 * SCN + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACKD = 2'd1, ACKE = 2'd2} state_t;

  // Handshake: out_valid means the head entry is stable; it is consumed on any
  // clock edge where out_valid and out_ready are both high.

  logic [IW-1:0] sync_q [SYNC];
  logic [IW-1:0] s_all;
  logic [SCN-1:0] s0, s1, s2, s3;
  logic s4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {d4, d3, d2, d1, d0};
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_all = sync_q[SYNC-1];
  assign s0    = s_all[SCN-1:0];
  assign s1    = s_all[2*SCN-1:SCN];
  assign s2    = s_all[3*SCN-1:2*SCN];
  assign s3    = s_all[4*SCN-1:3*SCN];
  assign s4    = s_all[4*SCN];

  logic [DW-1:0] word;
  logic [3:0]    hot;
  logic          any_zero, any_multi, any_set;

  // Bit 0 of the index is set by wires 1/3, bit 1 by wires 2/3 (valid when one-hot).
  always_comb begin
    word      = '0;
    hot       = '0;
    any_zero  = 1'b0;
    any_multi = 1'b0;
    any_set   = 1'b0;
    for (int k = 0; k < SCN; k++) begin
      hot = {s3[k], s2[k], s1[k], s0[k]};
      if (hot == 4'd0) any_zero = 1'b1;
      else             any_set  = 1'b1;
      if ((hot & (hot - 4'd1)) != 4'd0) any_multi = 1'b1;
      word[2*k +: 2] = {s2[k] | s3[k], s1[k] | s3[k]};
    end
  end

  logic complete, data_zero, bad, full;
  assign complete  = !any_zero && !any_multi;
  assign data_zero = !any_set;
  assign bad       = any_multi || (s4 && any_set);
  assign full      = !(count < CW'(DEPTH));

  state_t st, st_nxt;
  logic   a_nxt, a4_nxt, push, push_eof, err_set, pop;

  always_comb begin
    st_nxt   = st;
    a_nxt    = a;
    a4_nxt   = a4;
    push     = 1'b0;
    push_eof = 1'b0;
    err_set  = 1'b0;
    case (st)
      IDLE: begin
        if (bad) begin
          err_set = 1'b1;
        end else if (complete && !s4 && !full) begin
          push   = 1'b1;
          a_nxt  = 1'b1;
          st_nxt = ACKD;
        end else if (s4 && data_zero && !full) begin
          push     = 1'b1;
          push_eof = 1'b1;
          a4_nxt   = 1'b1;
          st_nxt   = ACKE;
        end
      end
      ACKD: if (data_zero) begin
        a_nxt  = 1'b0;
        st_nxt = IDLE;
      end
      ACKE: if (!s4) begin
        a4_nxt = 1'b0;
        st_nxt = IDLE;
      end
      default: begin
        a_nxt  = 1'b0;
        a4_nxt = 1'b0;
        st_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      a   <= 1'b0;
      a4  <= 1'b0;
      err <= 1'b0;
    end else begin
      st  <= st_nxt;
      a   <= a_nxt;
      a4  <= a4_nxt;
      err <= err | err_set;
    end
  end

  assign state = st;

  logic [DW:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_eof, push_eof ? {DW{1'b0}} : word};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid           = (count != '0);
  assign {out_eof, out_data} = mem[rd_ptr];

endmodule

// File: tb/tb_clos_port_rx.sv
// Bench for clos_port_rx: directed 4-phase scenarios plus random traffic, with an
// in-order word queue as the reference and a monitor that checks every pop.
module tb_clos_port_rx;

  localparam int DW = 8, SCN = 4, DEPTH = 4, SYNC = 2, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SCN-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic d4 = 1'b0;
  logic out_ready = 1'b1;
  logic a, a4, out_eof, out_valid, err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic [1:0] state;

  clos_port_rx #(.DW(DW), .SCN(SCN), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .a(a), .a4(a4),
    .out_data(out_data), .out_eof(out_eof), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] exp_e;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_wires();
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = 1'b0;
  endtask

  task automatic raise_digit(input int k, input logic [1:0] v);
    case (v)
      2'd0: d0[k] = 1'b1;
      2'd1: d1[k] = 1'b1;
      2'd2: d2[k] = 1'b1;
      default: d3[k] = 1'b1;
    endcase
  endtask

  task automatic drive_word(input logic [DW-1:0] w);
    clear_wires();
    for (int k = 0; k < SCN; k++) raise_digit(k, w[2*k +: 2]);
  endtask

  task automatic wait_ack(input bit on_eof, input logic level, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (((on_eof ? a4 : a) !== level) && cycles < budget);
    if ((on_eof ? a4 : a) !== level) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got %0b expected %0b after %0d cycles", on_eof ? a4 : a, level, cycles);
    end
  endtask

  task automatic send(input bit eof, input logic [DW-1:0] w);
    int c;
    if (eof) begin clear_wires(); d4 = 1'b1; end
    else drive_word(w);
    exp_q.push_back({eof, eof ? {DW{1'b0}} : w});
    wait_ack(eof, 1'b1, 200, c);
    clear_wires();
    wait_ack(eof, 1'b0, 200, c);
  endtask

  // Monitor: every accepted head entry must be the oldest outstanding token.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got %0h expected none", {out_eof, out_data});
        end else begin
          exp_e = exp_q.pop_front();
          check("pop_entry", {23'd0, out_eof, out_data}, {23'd0, exp_e});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit a_seen;
    logic [DW-1:0] w;

    repeat (3) tick();
    check("rst_a", a, 0);
    check("rst_a4", a4, 0);
    check("rst_valid", out_valid, 0);
    check("rst_eof", out_eof, 0);
    check("rst_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // Single word 0xB4 from explicit wire pattern
    d0 = 4'b0001; d1 = 4'b0010; d3 = 4'b0100; d2 = 4'b1000; d4 = 1'b0;
    exp_q.push_back({1'b0, 8'hB4});
    wait_ack(1'b0, 1'b1, 20, c);
    check("ack_rise_latency", c, SYNC + 1);
    check("valid_at_ack", out_valid, 1);
    check("data_at_ack", out_data, 8'hB4);
    tick();
    check("valid_one_cycle", out_valid, 0);
    clear_wires();
    wait_ack(1'b0, 1'b0, 20, c);
    check("ack_fall_latency", c, SYNC + 1);

    // eof token
    d4 = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    a_seen = 1'b0;
    c = 0;
    do begin tick(); c++; if (a) a_seen = 1'b1; end while (!a4 && c < 20);
    check("eof_ack_rise", a4, 1);
    check("eof_head", {out_eof, out_data}, {1'b1, 8'h00});
    d4 = 1'b0;
    c = 0;
    do begin tick(); c++; if (a) a_seen = 1'b1; end while (a4 && c < 20);
    check("eof_ack_fall", a4, 0);
    check("eof_no_data_ack", a_seen, 0);

    // Fill the FIFO; fifth token must wait for space
    out_ready = 1'b0;
    send(1'b0, 8'h00);
    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    send(1'b0, 8'hFF);
    check("full_count", count, 4);
    drive_word(8'h12);
    exp_q.push_back({1'b0, 8'h12});
    repeat (SYNC + 4) tick();
    check("full_no_ack", a, 0);
    check("full_count_hold", count, 4);
    out_ready = 1'b1;
    tick();
    check("first_pop_count", count, 3);
    check("no_ack_same_cycle", a, 0);
    tick();
    check("ack_after_free", a, 1);
    check("pushpop_count", count, 3);
    clear_wires();
    wait_ack(1'b0, 1'b0, 20, c);
    repeat (4) tick();
    check("drain_count", count, 0);
    check("drain_queue", exp_q.size(), 0);

    // Multi-hot code is a sticky error with no push
    d0[0] = 1'b1; d1[0] = 1'b1;
    repeat (SYNC + 3) tick();
    check("multi_err", err, 1);
    check("multi_no_ack", a, 0);
    check("multi_count", count, 0);
    clear_wires();
    repeat (SYNC + 1) tick();
    send(1'b0, 8'h3C);
    check("err_sticky", err, 1);
    repeat (2) tick();
    check("multi_queue", exp_q.size(), 0);

    // Skewed arrival: one sub-channel per step
    w = 8'($urandom);
    clear_wires();
    for (int k = 0; k < SCN - 1; k++) begin
      raise_digit(k, w[2*k +: 2]);
      repeat (SYNC + 2) tick();
      check("skew_no_ack", a, 0);
    end
    exp_q.push_back({1'b0, w});
    raise_digit(SCN - 1, w[2*(SCN-1) +: 2]);
    wait_ack(1'b0, 1'b1, 20, c);
    check("skew_latency", c, SYNC + 1);
    clear_wires();
    wait_ack(1'b0, 1'b0, 20, c);
    repeat (2) tick();
    check("skew_queue", exp_q.size(), 0);

    // Reset mid-handshake with two entries buffered
    out_ready = 1'b0;
    send(1'b0, 8'h11);
    drive_word(8'h22);
    exp_q.push_back({1'b0, 8'h22});
    wait_ack(1'b0, 1'b1, 20, c);
    check("pre_rst_count", count, 2);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_a", a, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_err", err, 0);
    clear_wires();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    send(1'b0, 8'h5A);
    repeat (3) tick();
    check("post_rst_queue", exp_q.size(), 0);

    // Random traffic with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send($urandom_range(0, 3) == 0, 8'($urandom));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    check("rand_queue", exp_q.size(), 0);
    check("rand_count", count, 0);
    check("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
